// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART TX line between N_REQ byte-stream requesters. A requester
//   wins the line round-robin and keeps it (grant held) until it hands over a
//   byte flagged as last, or until an optional idle timeout releases it. Each
//   accepted byte is sent as 8N1 (start, 8 data bits LSB first, stop) with
//   CLK_DIV sys_clk cycles per bit.
//
// Ports
//   sys_clk_i    in   1        system clock
//   rstn_i       in   1        synchronous active-low reset
//   req_valid_i  in   N_REQ    requester k presents a byte
//   req_data_i   in   8*N_REQ  byte of requester k at [8k+:8]
//   req_last_i   in   N_REQ    byte ends the requester's frame
//   req_ready_o  out  N_REQ    one-cycle accept strobe (combinational, one-hot)
//   grant_o      out  N_REQ    one-hot frame owner, 0 when unlocked
//   busy_o       out  1        serializer active or a frame is locked
//   uart_tx_o    out  1        serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ         = 2,
    parameter int CLK_DIV       = 868,
    parameter int FRAME_TIMEOUT = 0
) (
    input  logic                 sys_clk_i,
    input  logic                 rstn_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 uart_tx_o
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W   = (FRAME_TIMEOUT > 0) ? $clog2(FRAME_TIMEOUT + 1) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    // Only meaningful when FRAME_TIMEOUT > 0; the comparison is never reached otherwise.
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(FRAME_TIMEOUT - 1);
    localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int j = 0; j < N_REQ; j++) begin
            v[j] = (PTR_W'(j) == idx) ? 1'b1 : 1'b0;
        end
        return v;
    endfunction

    // Registered state
    state_t              state_r;
    logic [BAUD_W-1:0]   baud_r;
    logic [2:0]          bit_r;
    logic [7:0]          shift_r;
    logic                last_r;
    logic                locked_r;
    logic [PTR_W-1:0]    owner_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic                tx_r;
    logic [N_REQ-1:0]    grant_r;
    logic                busy_r;

    // Next-state values
    state_t              state_s;
    logic [BAUD_W-1:0]   baud_s;
    logic [2:0]          bit_s;
    logic [7:0]          shift_s;
    logic                last_s;
    logic                locked_s;
    logic [PTR_W-1:0]    owner_s;
    logic [PTR_W-1:0]    ptr_s;
    logic [TO_W-1:0]     to_cnt_s;
    logic                tx_s;
    logic [N_REQ-1:0]    grant_s;
    logic                busy_s;
    logic [N_REQ-1:0]    ready_s;

    // Arbitration / selection
    logic [PTR_W-1:0]    hi_idx_s;
    logic                hi_found_s;
    logic [PTR_W-1:0]    lo_idx_s;
    logic                lo_found_s;
    logic [PTR_W-1:0]    winner_s;
    logic                win_found_s;
    logic [PTR_W-1:0]    sel_idx_s;
    logic                sel_valid_s;
    logic [7:0]          sel_data_s;
    logic                sel_last_s;

    // Round-robin scan: first valid above the pointer, else first valid at or below it.
    always_comb begin
        hi_idx_s   = '0;
        hi_found_s = 1'b0;
        lo_idx_s   = '0;
        lo_found_s = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (req_valid_i[j] && (PTR_W'(j) > ptr_r) && !hi_found_s) begin
                hi_idx_s   = PTR_W'(j);
                hi_found_s = 1'b1;
            end else begin
                hi_found_s = hi_found_s;
            end
            if (req_valid_i[j] && (PTR_W'(j) <= ptr_r) && !lo_found_s) begin
                lo_idx_s   = PTR_W'(j);
                lo_found_s = 1'b1;
            end else begin
                lo_found_s = lo_found_s;
            end
        end
        winner_s    = hi_found_s ? hi_idx_s : lo_idx_s;
        win_found_s = hi_found_s | lo_found_s;
    end

    // Select the requester of interest: the owner while locked, else the arbitration winner.
    always_comb begin
        sel_idx_s   = locked_r ? owner_r : winner_s;
        sel_valid_s = 1'b0;
        sel_data_s  = 8'h00;
        sel_last_s  = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (PTR_W'(j) == sel_idx_s) begin
                sel_valid_s = req_valid_i[j];
                sel_data_s  = req_data_i[8*j +: 8];
                sel_last_s  = req_last_i[j];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // FSM next-state, accept strobe, lock and timeout handling.
    always_comb begin
        state_s  = state_r;
        baud_s   = baud_r;
        bit_s    = bit_r;
        shift_s  = shift_r;
        last_s   = last_r;
        locked_s = locked_r;
        owner_s  = owner_r;
        ptr_s    = ptr_r;
        to_cnt_s = to_cnt_r;
        ready_s  = '0;
        case (state_r)
            ST_IDLE: begin
                baud_s = '0;
                bit_s  = 3'd0;
                if (locked_r) begin
                    if (sel_valid_s) begin
                        // Owner accept has priority over a timeout expiring this cycle.
                        ready_s  = onehot(owner_r);
                        shift_s  = sel_data_s;
                        last_s   = sel_last_s;
                        to_cnt_s = '0;
                        state_s  = ST_START;
                    end else if (FRAME_TIMEOUT > 0) begin
                        if (to_cnt_r == TO_LAST) begin
                            locked_s = 1'b0;
                            to_cnt_s = '0;
                        end else begin
                            to_cnt_s = to_cnt_r + TO_W'(1);
                        end
                    end else begin
                        to_cnt_s = '0;
                    end
                end else if (win_found_s) begin
                    ready_s  = onehot(winner_s);
                    owner_s  = winner_s;
                    ptr_s    = winner_s;
                    locked_s = 1'b1;
                    shift_s  = sel_data_s;
                    last_s   = sel_last_s;
                    to_cnt_s = '0;
                    state_s  = ST_START;
                end else begin
                    to_cnt_s = '0;
                end
            end
            ST_START: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = '0;
                    bit_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = '0;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = '0;
                    state_s = ST_IDLE;
                    if (last_r) begin
                        locked_s = 1'b0;
                    end else begin
                        locked_s = locked_r;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s  = ST_IDLE;
                baud_s   = '0;
                bit_s    = 3'd0;
                locked_s = 1'b0;
            end
        endcase
    end

    // Output values computed from the next state so the registered outputs line up with it.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            ST_STOP:  tx_s = 1'b1;
            ST_IDLE:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
        grant_s = locked_s ? onehot(owner_s) : '0;
        busy_s  = (state_s != ST_IDLE) || locked_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) begin
            state_r  <= ST_IDLE;
            baud_r   <= '0;
            bit_r    <= 3'd0;
            shift_r  <= 8'h00;
            last_r   <= 1'b0;
            locked_r <= 1'b0;
            owner_r  <= '0;
            ptr_r    <= PTR_RST;
            to_cnt_r <= '0;
            tx_r     <= 1'b1;
            grant_r  <= '0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            baud_r   <= baud_s;
            bit_r    <= bit_s;
            shift_r  <= shift_s;
            last_r   <= last_s;
            locked_r <= locked_s;
            owner_r  <= owner_s;
            ptr_r    <= ptr_s;
            to_cnt_r <= to_cnt_s;
            tx_r     <= tx_s;
            grant_r  <= grant_s;
            busy_r   <= busy_s;
        end
    end

    // The accept strobe is combinational; it is held off while reset is asserted.
    assign req_ready_o = rstn_i ? ready_s : '0;
    assign grant_o     = grant_r;
    assign busy_o      = busy_r;
    assign uart_tx_o   = tx_r;

endmodule
